// File: rtl/count_seq_ctrl.sv
// Run/stop/clear sequencer for a 0..limit up-counter repeated for a programmed number of passes.
// Supports pause and abort, and reports wrap, busy, done and start errors.
module count_seq_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned PASS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              paused,
  output logic              wrap,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              err_q, err_d;
  logic              at_limit;
  logic [PASS_W-1:0] pass_inc;

  assign at_limit = (count_q == limit_q);
  assign pass_inc = pass_q + PASS_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      limit_q  <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      limit_q  <= limit_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (passes != '0) begin
            limit_d  = limit;
            passes_d = passes;
            count_d  = '0;
            pass_d   = '0;
            state_d  = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun, StPaused: begin
        if (abort) begin
          count_d = '0;
          pass_d  = '0;
          state_d = StIdle;
        end else if (pause) begin
          state_d = StPaused;
        end else begin
          // The edge that leaves PAUSED also advances the count, so the pause
          // costs exactly as many cycles as pause was held.
          state_d = StRun;
          if (at_limit) begin
            count_d = '0;
            pass_d  = pass_inc;
            if (pass_inc == passes_q) begin
              state_d = StDone;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      StDone: begin
        count_d = '0;
        if (abort) begin
          pass_d = '0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q == StRun) || (state_q == StPaused);
    paused = (state_q == StPaused);
    done   = (state_q == StDone);
    wrap   = (state_q == StRun) && !pause && !abort && at_limit;
  end

  assign count    = count_q;
  assign pass_cnt = pass_q;
  assign err      = err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: expected per-cycle outputs are queued as stimulus is
// driven, then popped and checked against the DUT in that same cycle.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] limit = '0;
  logic [3:0] passes = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic [3:0] pass_cnt;
  logic       busy, paused, wrap, done, err;

  typedef struct packed {
    logic [3:0] count;
    logic [3:0] pass;
    logic       busy;
    logic       paused;
    logic       wrap;
    logic       done;
    logic       err;
  } obs_t;

  obs_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    busy_cycles = 0;
  int    done_cycles = 0;
  string tag = "reset";

  count_seq_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .limit(limit), .passes(passes),
    .pause(pause), .abort(abort), .count(count), .pass_cnt(pass_cnt), .busy(busy),
    .paused(paused), .wrap(wrap), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic push(input int c, input int p, input bit b, input bit pz, input bit w,
                      input bit d, input bit e);
    obs_t o;
    o.count = 4'(c);
    o.pass = 4'(p);
    o.busy = b;
    o.paused = pz;
    o.wrap = w;
    o.done = d;
    o.err = e;
    sb.push_back(o);
  endtask

  task automatic check_now();
    obs_t e, a;
    a = '{count: count, pass: pass_cnt, busy: busy, paused: paused, wrap: wrap, done: done,
          err: err};
    busy_cycles += int'(busy);
    done_cycles += int'(done);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, a);
    end else begin
      e = sb.pop_front();
      assert (a === e) else begin
        bad++;
        $error("FAIL %s: got cnt=%0d pass=%0d busy=%b paused=%b wrap=%b done=%b err=%b, expected cnt=%0d pass=%0d busy=%b paused=%b wrap=%b done=%b err=%b",
               tag, a.count, a.pass, a.busy, a.paused, a.wrap, a.done, a.err,
               e.count, e.pass, e.busy, e.paused, e.wrap, e.done, e.err);
      end
    end
  endtask

  // Called at a falling edge: apply this cycle's inputs, check, move to the next falling edge.
  task automatic step(input logic st, input logic pa, input logic ab);
    start = st;
    pause = pa;
    abort = ab;
    #1;
    check_now();
    @(negedge clk);
  endtask

  task automatic run_basic(input int prev_pass, input bit mid_start);
    limit = 4'd3;
    passes = 4'd2;
    push(0, prev_pass, 0, 0, 0, 0, 0);
    step(1, 0, 0);
    limit = 4'd9;  // latched values must not follow later input changes
    passes = 4'd5;
    for (int i = 0; i < 8; i++) begin
      push(i % 4, i / 4, 1, 0, (i % 4) == 3, 0, 0);
      step(mid_start && (i == 2), 0, 0);
    end
    push(0, 2, 0, 0, 0, 1, 0);
    step(0, 0, 0);
    push(0, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    push(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0);
    reset = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0);

    tag = "basic";
    run_basic(0, 1);

    tag = "pause";
    busy_cycles = 0;
    done_cycles = 0;
    limit = 4'd3;
    passes = 4'd2;
    push(0, 2, 0, 0, 0, 0, 0); step(1, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0); step(0, 0, 0);
    push(1, 0, 1, 0, 0, 0, 0); step(0, 0, 0);
    push(2, 0, 1, 0, 0, 0, 0); step(0, 1, 0);
    push(2, 0, 1, 1, 0, 0, 0); step(0, 1, 0);
    push(2, 0, 1, 1, 0, 0, 0); step(0, 1, 0);
    push(2, 0, 1, 1, 0, 0, 0); step(0, 0, 0);
    push(3, 0, 1, 0, 1, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push(i, 1, 1, 0, i == 3, 0, 0);
      step(0, 0, 0);
    end
    push(0, 2, 0, 0, 0, 1, 0); step(0, 0, 0);
    push(0, 2, 0, 0, 0, 0, 0); step(0, 0, 0);
    total++;
    assert (busy_cycles === 11) else begin
      bad++;
      $error("FAIL pause_busy: got %0d busy cycles, expected 11", busy_cycles);
    end
    total++;
    assert (done_cycles === 1) else begin
      bad++;
      $error("FAIL pause_done: got %0d done cycles, expected 1", done_cycles);
    end

    tag = "abort";
    limit = 4'd7;
    passes = 4'd3;
    push(0, 2, 0, 0, 0, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      push(i, 0, 1, 0, i == 7, 0, 0);
      step(0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      push(i, 1, 1, 0, 0, 0, 0);
      step(0, 0, 0);
    end
    push(5, 1, 1, 0, 0, 0, 0); step(0, 0, 1);
    push(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0);

    tag = "err";
    limit = 4'd5;
    passes = 4'd0;
    push(0, 0, 0, 0, 0, 0, 0); step(1, 0, 0);
    push(0, 0, 0, 0, 0, 0, 1); step(0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0);

    tag = "abort_idle";
    limit = 4'd3;
    passes = 4'd2;
    push(0, 0, 0, 0, 0, 0, 0); step(1, 0, 1);
    push(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0);

    tag = "limit0";
    limit = 4'd0;
    passes = 4'd4;
    push(0, 0, 0, 0, 0, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push(0, i, 1, 0, 1, 0, 0);
      step(0, 0, 0);
    end
    push(0, 4, 0, 0, 0, 1, 0); step(0, 0, 0);
    push(0, 4, 0, 0, 0, 0, 0); step(0, 0, 0);

    tag = "reset_mid";
    limit = 4'd3;
    passes = 4'd2;
    push(0, 4, 0, 0, 0, 0, 0); step(1, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0); step(0, 0, 0);
    push(1, 0, 1, 0, 0, 0, 0); step(0, 0, 0);
    start = 1'b0;
    push(2, 0, 1, 0, 0, 0, 0);
    #1;
    check_now();
    #2;
    reset = 1'b1;
    #1;
    push(0, 0, 0, 0, 0, 0, 0);
    check_now();
    @(negedge clk);
    push(0, 0, 0, 0, 0, 0, 0); step(0, 0, 0);
    reset = 1'b0;

    tag = "basic_after_reset";
    run_basic(0, 0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
